sipo_word_capture: RTL and testbench
====================================

// Module: sipo_word_capture
// PURPOSE
//  Sits directly downstream of the right-shift SIPO register. Counts serial bits shifted
//  in (same enb that drives the SIPO), and once DW bits are in, snapshots the SIPO parallel
//  output into a one-word holding buffer presented on a valid/ready interface.
//  It turns a free-running shift register into framed, flow-controlled parallel words.
// PARAMETERS
//  DW   4   word width; must equal the SIPO's DW; DW >= 2
//  CW   $clog2(DW)  localparam, bit-counter width (not overridable)
// PORTS
//  clk        in   1    clock; all logic on posedge
//  rst        in   1    asynchronous, active-high reset
//  enb        in   1    shift strobe; same signal driving the SIPO enb
//  sof        in   1    start-of-frame; re-aligns bit counter (bit on this cycle = bit 0)
//  sipo_data  in   DW   parallel output of the SIPO (registered in the SIPO)
//  out_data   out  DW   captured word
//  out_valid  out  1    out_data holds an unconsumed word
//  out_ready  in   1    consumer accepts word when out_valid & out_ready at posedge
//  ovf        out  1    sticky: a completed word was dropped because buffer was full
//  ovf_clr    in   1    synchronous clear of ovf
//  bit_cnt    out  CW   bits collected in current word (debug/status)
// BEHAVIOUR
//  Reset (rst=1, async): bit_cnt=0, cap_pend=0, out_data=0, out_valid=0, ovf=0.
//  Bit counter, per posedge:
//   - sof & enb: bit_cnt <= 1 (this bit is bit 0 of new word); pending capture cancelled.
//   - sof & !enb: bit_cnt <= 0; pending capture cancelled.
//   - !sof & enb: bit_cnt==DW-1 -> bit_cnt <= 0 and cap_pend <= 1; else bit_cnt+1.
//   - else hold.
//  Capture: SIPO output reflects the DW-th shift one cycle after it, so capture happens on
//   the posedge following the one that set cap_pend (latency: word on out_data 1 cycle
//   after the DW-th enb edge, out_valid same cycle). cap_pend self-clears on that edge.
//   Sampling is of pre-edge sipo_data, so a new enb on the capture cycle is safe
//   (back-to-back words at 1 bit/cycle sustain full rate).
//  Buffer (one entry), on capture edge:
//   - out_valid=0, or out_valid & out_ready: load sipo_data, out_valid<=1 (pop+load same
//     edge allowed, no bubble).
//   - out_valid & !out_ready: new word dropped, out_data unchanged, ovf<=1.
//  Non-capture edge: out_valid & out_ready -> out_valid<=0; out_data holds last value.
//  ovf: set as above; ovf_clr clears it; set and clear same edge -> set wins.
//  out_data stable while out_valid & !out_ready (AXI-style hold rule).
//  Reset mid-word: discards partial count, pending capture and buffered word.
//  Bits in SIPO order: first bit received ends in out_data[0], last in out_data[DW-1].
// CONFIGURATION
//  SIPO_CAP_DROP_CNT_EN defined: adds output drop_cnt [7:0], saturating count of dropped
//   words (increments at 255 hold); cleared by rst and by ovf_clr (set wins over clear,
//   count becomes 1 if clear and drop coincide from any value).
//  Not defined: no drop_cnt port, no counter logic; ovf flag only.
// TESTING (DW=4 unless noted)
//  1 Reset: rst pulse mid-run -> all outputs 0 immediately (async), bit_cnt 0.
//  2 sof then serial 1,0,1,1 on enb=1 each cycle, out_ready=1 -> out_data=4'b1101,
//    out_valid high for 1 cycle, 1 cycle after 4th shift edge.
//  3 Continuous 8 bits 1,1,0,0,0,1,0,1, out_ready=1 -> words 4'b0011 then 4'b1010, no gap.
//  4 out_ready=0, two full words -> first held (4'b0011), second dropped, ovf=1; ovf_clr
//    -> ovf=0; with SIPO_CAP_DROP_CNT_EN drop_cnt=1 before clear, 0 after.
//  5 sof asserted after 2 bits with enb=1 -> bit_cnt=1; word completes 3 bits later, not 2.
//  6 Gapped enb (1 bit every 3 cycles) -> same word as scenario 2, captured 1 cycle after
//    4th enb edge; out_data held stable while out_ready=0 for 5 cycles.

Source files
------------

// File: rtl/sipo_word_capture.sv
// sipo_word_capture: frames the parallel output of a right-shift SIPO into
// DW-bit words and holds each word in a one-entry valid/ready buffer.
// Optional feature macro: SIPO_CAP_DROP_CNT_EN adds a saturating drop_cnt output.
module sipo_word_capture #(
    parameter  int DW = 4,
    localparam int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          sof,
    input  logic [DW-1:0] sipo_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf,
    input  logic          ovf_clr,
`ifdef SIPO_CAP_DROP_CNT_EN
    output logic [7:0]    drop_cnt,
`endif
    output logic [CW-1:0] bit_cnt
);

    // cap_pend marks that the SIPO finished a word on the previous edge; its
    // parallel output only shows that word now, so the snapshot happens here.
    logic cap_pend;
    logic capture;
    logic pop;
    logic drop;

    // A start-of-frame on the capture edge cancels the pending word.
    assign capture = cap_pend & ~sof;
    assign pop     = out_valid & out_ready;
    assign drop    = capture & out_valid & ~out_ready;

    // Bit counter and word-complete detection; sof re-aligns the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= 1'b0;
            if (sof) begin
                bit_cnt <= enb ? CW'(1) : '0;
            end else if (enb) begin
                if (bit_cnt == CW'(DW - 1)) begin
                    bit_cnt  <= '0;
                    cap_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // One-entry holding buffer; pop and reload on the same edge leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (capture && (!out_valid || out_ready)) begin
            out_data  <= sipo_data;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef SIPO_CAP_DROP_CNT_EN
    // Saturating count of dropped words; a drop coinciding with a clear restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_word_capture.sv
// Bench for sipo_word_capture: directed scenarios plus randomized traffic,
// every cycle compared with a bit-list / one-slot-buffer reference model.
module tb_sipo_word_capture;
    localparam int DW = 4;
    localparam int CW = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst;
    logic          enb, sof, out_ready, ovf_clr;
    logic [DW-1:0] sipo_data;
    logic [DW-1:0] out_data;
    logic          out_valid, ovf;
    logic [CW-1:0] bit_cnt;
`ifdef SIPO_CAP_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    sipo_word_capture #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .enb(enb), .sof(sof), .sipo_data(sipo_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .ovf_clr(ovf_clr),
`ifdef SIPO_CAP_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits of the current word in arrival order, a word
    // waiting one cycle for the SIPO output, and the one-slot buffer.
    bit            m_bits[$];
    bit            m_pend;
    logic [DW-1:0] m_pend_word;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ovf;
    int            m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pend = 1'b0; m_pend_word = '0;
        m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_drop = 0;
    endtask

    task automatic check_all();
        chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SIPO_CAP_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic s, input logic e, input logic d, input logic r, input logic c);
        bit cap, drp;
        sof = s; enb = e; out_ready = r; ovf_clr = c;
        cap = m_pend && !s;
        drp = cap && m_valid && !r;
        if (cap && !drp) begin
            m_valid = 1'b1; m_data = m_pend_word;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (drp) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (drp) m_drop = c ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        else if (c) m_drop = 0;
        m_pend = 1'b0;
        if (s) begin
            m_bits.delete();
            if (e) m_bits.push_back(d);
        end else if (e) begin
            m_bits.push_back(d);
            if (m_bits.size() == DW) begin
                m_pend = 1'b1;
                for (int i = 0; i < DW; i++) m_pend_word[i] = m_bits[i];
                m_bits.delete();
            end
        end
        @(posedge clk);
        #1;
        if (e) sipo_data = {d, sipo_data[DW-1:1]};
        check_all();
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic first_sof, input logic r);
        for (int i = 0; i < DW; i++) step(first_sof && i == 0, 1'b1, w[i], r, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sof = 1'b0; enb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        sipo_data = '0;
        model_reset();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // Single framed word 1,0,1,1 -> 4'b1101, visible one cycle after the 4th shift.
        send_word(4'b1101, 1'b1, 1'b1);
        chk("s2_no_early_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("s2_valid", 32'(out_valid), 32'd1);
        chk("s2_data", 32'(out_data), 32'hD);
        step(0, 0, 0, 1, 0);
        chk("s2_valid_one_cycle", 32'(out_valid), 32'd0);

        // Back-to-back words at full rate.
        send_word(4'b0011, 1'b1, 1'b1);
        step(0, 1, 0, 1, 0);
        chk("s3_w0", 32'(out_data), 32'h3);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("s3_w1", 32'(out_data), 32'hA);
        chk("s3_w1_valid", 32'(out_valid), 32'd1);
        step(0, 0, 0, 1, 0);

        // Overflow: consumer stalled across two words.
        send_word(4'b0011, 1'b1, 1'b0);
        send_word(4'b1010, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("s4_held", 32'(out_data), 32'h3);
        chk("s4_ovf", 32'(ovf), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("s4_ovf_clr", 32'(ovf), 32'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Re-alignment mid-word.
        step(1, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("s5_bit_cnt", 32'(bit_cnt), 32'd1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("s5_not_yet", 32'(m_pend), 32'd0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("s5_word", 32'(out_data), 32'hD);
        step(0, 0, 0, 1, 0);

        // Gapped shifts, then consumer stalls for 5 cycles.
        for (int i = 0; i < DW; i++) begin
            logic [DW-1:0] w;
            w = 4'b1101;
            step(i == 0, 1, w[i], 0, 0);
            if (i < DW - 1) begin
                step(0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("s6_hold", 32'(out_data), 32'hD);
        end
        step(0, 0, 0, 1, 0);

        // Randomized traffic with an asynchronous reset dropped in mid-run.
        for (int n = 0; n < 3000; n++) begin
            logic s, e, d, r, c;
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 19) == 0) && !m_pend;
            d = 1'($urandom);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 15) == 0);
            if (n == 1500) begin
                #3 rst = 1'b1;
                #1;
                model_reset();
                check_all();
                @(posedge clk); #1;
                rst = 1'b0;
                check_all();
            end
            step(s, e, d, r, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
